sm4_mode_engine: RTL

Parametrised successor to the SM4 top level: an iterative SM4 engine with its own on-the-fly key schedule. The key schedule fills a 32-entry round-key store. The datapath runs a configurable number of rounds per clock and supports ECB and CBC chaining, plus CTR as an optional feature. It sits between the bus/DMA front end and the data buffers, with a single valid/ready handshake for blocks and a separate key-load strobe.

---
 rtl/sm4_pkg.sv | 47 ++++
 rtl/sm4_round.sv | 25 ++
 rtl/sm4_mode_engine.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sm4_pkg.sv
// SM4 primitives shared by the mode engine: S-box, FK/CK constants, tau and the two linear maps.
package sm4_pkg;

   localparam logic [1:0] MODE_ECB = 2'b00;
   localparam logic [1:0] MODE_CBC = 2'b01;
   localparam logic [1:0] MODE_CTR = 2'b10;

   localparam logic [127:0] FK = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;

   // Entry 0 is the leftmost byte.
   localparam logic [0:255][7:0] SBOX = {
      128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
   };

   function automatic logic [31:0] rotl(input logic [31:0] b, input int unsigned n);
      return (b << n) | (b >> (32 - n));
   endfunction

   function automatic logic [31:0] tau(input logic [31:0] a);
      logic [31:0] b;
      for (int i = 0; i < 4; i++) b[8*i +: 8] = SBOX[a[8*i +: 8]];
      return b;
   endfunction

   function automatic logic [31:0] l_enc(input logic [31:0] b);
      return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
   endfunction

   function automatic logic [31:0] l_key(input logic [31:0] b);
      return b ^ rotl(b, 13) ^ rotl(b, 23);
   endfunction

   // CK[i] byte j (j = 0 is the MSB) is (4i+j)*7 mod 256.
   function automatic logic [31:0] ck(input logic [4:0] i);
      logic [31:0] c;
      for (int j = 0; j < 4; j++) c[31-8*j -: 8] = 8'((4 * int'(i) + j) * 7);
      return c;
   endfunction

endpackage

// File: rtl/sm4_round.sv
// One combinational SM4 round; KEY_SCHED selects the key-schedule linear map L'.
module sm4_round
   import sm4_pkg::*;
#(
   parameter bit KEY_SCHED = 1'b0
) (
   input  logic [127:0] x_i,
   input  logic [31:0]  rk_i,
   output logic [127:0] y_o
);

   logic [31:0] t_in;
   logic [31:0] t_out;

   assign t_in = x_i[95:64] ^ x_i[63:32] ^ x_i[31:0] ^ rk_i;

   if (KEY_SCHED) begin : g_key
      assign t_out = l_key(tau(t_in));
   end else begin : g_enc
      assign t_out = l_enc(tau(t_in));
   end

   assign y_o = {x_i[95:0], x_i[127:96] ^ t_out};

endmodule

// File: rtl/sm4_mode_engine.sv
// Iterative SM4 engine with on-the-fly key schedule, ECB/CBC chaining and
// optional CTR mode (enabled by defining SM4_CTR_MODE_EN).
module sm4_mode_engine
   import sm4_pkg::*;
#(
   parameter int unsigned ROUNDS_PER_CYCLE     = 1,
   parameter int unsigned KEY_ROUNDS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         key_load_in,
   input  logic [127:0] user_key_in,
   output logic         key_ready_out,
   input  logic         iv_load_in,
   input  logic [127:0] iv_in,
   input  logic [1:0]   mode_in,
   input  logic         encdec_sel_in,
   input  logic         start_in,
   output logic         ready_out,
   input  logic [127:0] data_in,
   output logic         result_valid_out,
   output logic [127:0] result_out
);

   localparam int unsigned NCYC  = 32 / ROUNDS_PER_CYCLE;
   localparam int unsigned KCYC  = 32 / KEY_ROUNDS_PER_CYCLE;
   localparam logic [4:0]  NLAST = 5'(NCYC - 1);
   localparam logic [4:0]  KLAST = 5'(KCYC - 1);

   typedef enum logic [1:0] {StIdle, StKey, StCrypt, StOut} state_e;

   state_e       state_q;
   logic [4:0]   cnt_q;
   logic [127:0] kwin_q, x_q, chain_q, data_q, result_q;
   logic [1:0]   mode_q;
   logic         dec_q, key_ready_q, result_valid_q;
   logic [31:0]  rk_q [32];

   logic [127:0] x_chain [ROUNDS_PER_CYCLE+1];
   logic [127:0] k_chain [KEY_ROUNDS_PER_CYCLE+1];
   logic [31:0]  rk_sel  [ROUNDS_PER_CYCLE];
   logic [31:0]  ck_sel  [KEY_ROUNDS_PER_CYCLE];

   logic         accept;
   logic [1:0]   mode_eff;
   logic [127:0] chain_eff, x_in, y_blk, result_d, chain_d;

   assign x_chain[0] = x_q;
   assign k_chain[0] = kwin_q;

   for (genvar r = 0; r < ROUNDS_PER_CYCLE; r++) begin : g_round
      logic [4:0] idx;
      assign idx = 5'(cnt_q * ROUNDS_PER_CYCLE + r);
      // ~idx == 31 - idx: decryption walks the key store backwards.
      assign rk_sel[r] = dec_q ? rk_q[~idx] : rk_q[idx];
      sm4_round #(.KEY_SCHED(1'b0)) u_round (
         .x_i  (x_chain[r]),
         .rk_i (rk_sel[r]),
         .y_o  (x_chain[r+1])
      );
   end

   for (genvar k = 0; k < KEY_ROUNDS_PER_CYCLE; k++) begin : g_key
      assign ck_sel[k] = ck(5'(cnt_q * KEY_ROUNDS_PER_CYCLE + k));
      sm4_round #(.KEY_SCHED(1'b1)) u_key_round (
         .x_i  (k_chain[k]),
         .rk_i (ck_sel[k]),
         .y_o  (k_chain[k+1])
      );
   end

   assign ready_out        = (state_q == StIdle) & key_ready_q & ~key_load_in;
   assign accept           = start_in & ready_out;
   assign chain_eff        = iv_load_in ? iv_in : chain_q;
   assign y_blk            = {x_q[31:0], x_q[63:32], x_q[95:64], x_q[127:96]};
   assign key_ready_out    = key_ready_q;
   assign result_valid_out = result_valid_q;
   assign result_out       = result_q;

   always_comb begin
      mode_eff = MODE_ECB;
      if (mode_in == MODE_CBC) mode_eff = MODE_CBC;
`ifdef SM4_CTR_MODE_EN
      if (mode_in == MODE_CTR) mode_eff = MODE_CTR;
`endif
   end

   always_comb begin
      case (mode_eff)
         MODE_CBC: x_in = encdec_sel_in ? data_in : data_in ^ chain_eff;
         MODE_CTR: x_in = chain_eff;
         default:  x_in = data_in;
      endcase
   end

   always_comb begin
      result_d = y_blk;
      chain_d  = chain_q;
      case (mode_q)
         MODE_CBC: begin
            if (dec_q) begin
               result_d = y_blk ^ chain_q;
               chain_d  = data_q;
            end else begin
               chain_d  = y_blk;
            end
         end
`ifdef SM4_CTR_MODE_EN
         MODE_CTR: begin
            result_d = data_q ^ y_blk;
            chain_d  = chain_q + 128'd1;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= StIdle;
         cnt_q          <= '0;
         kwin_q         <= '0;
         x_q            <= '0;
         chain_q        <= '0;
         data_q         <= '0;
         result_q       <= '0;
         mode_q         <= MODE_ECB;
         dec_q          <= 1'b0;
         key_ready_q    <= 1'b0;
         result_valid_q <= 1'b0;
      end else begin
         result_valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (key_load_in) begin
                  kwin_q      <= user_key_in ^ FK;
                  key_ready_q <= 1'b0;
                  cnt_q       <= '0;
                  state_q     <= StKey;
               end else begin
                  if (iv_load_in) chain_q <= iv_in;
                  if (accept) begin
                     x_q     <= x_in;
                     data_q  <= data_in;
                     mode_q  <= mode_eff;
                     dec_q   <= encdec_sel_in & (mode_eff != MODE_CTR);
                     cnt_q   <= '0;
                     state_q <= StCrypt;
                  end
               end
            end
            StKey: begin
               kwin_q <= k_chain[KEY_ROUNDS_PER_CYCLE];
               cnt_q  <= cnt_q + 5'd1;
               if (cnt_q == KLAST) begin
                  key_ready_q <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            StCrypt: begin
               x_q   <= x_chain[ROUNDS_PER_CYCLE];
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == NLAST) state_q <= StOut;
            end
            StOut: begin
               result_q       <= result_d;
               chain_q        <= chain_d;
               result_valid_q <= 1'b1;
               state_q        <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Round-key store has no reset; it is only meaningful once key_ready_out is set.
   always_ff @(posedge clk) begin
      if (state_q == StKey) begin
         for (int k = 0; k < KEY_ROUNDS_PER_CYCLE; k++) begin
            rk_q[5'(cnt_q * KEY_ROUNDS_PER_CYCLE + k)] <= k_chain[k+1][31:0];
         end
      end
   end

endmodule
